// File: rtl/rtc_apb_master.sv
// Single-outstanding APB requester: turns a valid/ready command stream into
// SETUP/ACCESS transfers and returns one response (data, slave error, timeout).
module rtc_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  pclk,
  input  logic                  prst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_W-1:0]     m_apb_paddr,
  output logic                  m_apb_psel,
  output logic                  m_apb_penable,
  output logic                  m_apb_pwrite,
  output logic [DATA_W-1:0]     m_apb_pwdata,
  output logic [DATA_W/8-1:0]   m_apb_pstrb,
  input  logic                  m_apb_pready,
  input  logic [DATA_W-1:0]     m_apb_prdata,
  input  logic                  m_apb_pslverr
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_live;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_accept;
  logic                w_expire;
  logic [ADDR_W-1:0]   r_paddr;
  logic                r_pwrite;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // w_cnt_inc is the ACCESS-cycle count for the current cycle (first ACCESS = 1)
  assign w_cnt_inc = sat_inc(r_cnt);
  assign w_expire  = (TIMEOUT != 0) && (w_cnt_inc == TO_VAL);

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    cmd_ready     = 1'b0;
    m_apb_psel    = 1'b0;
    m_apb_penable = 1'b0;
    rsp_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = r_live;
        if (r_live && cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_SETUP;
        end
      end
      S_SETUP: begin
        m_apb_psel = 1'b1;
        w_next     = S_ACCESS;
      end
      S_ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = 1'b1;
        if (m_apb_pready || w_expire) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_live keeps cmd_ready low while reset is held and until the first clock after it
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state   <= S_IDLE;
      r_live    <= 1'b0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
        r_pstrb  <= cmd_write ? cmd_strb : '0;
        r_cnt    <= '0;
      end
      if (r_state == S_ACCESS) begin
        r_cnt <= w_cnt_inc;
        if (m_apb_pready) begin
          r_rdata   <= r_pwrite ? '0 : m_apb_prdata;
          r_err     <= m_apb_pslverr;
          r_timeout <= 1'b0;
        end else if (w_expire) begin
          r_rdata   <= '0;
          r_err     <= 1'b1;
          r_timeout <= 1'b1;
        end
      end
    end
  end

  assign m_apb_paddr  = r_paddr;
  assign m_apb_pwrite = r_pwrite;
  assign m_apb_pwdata = r_pwdata;
  assign m_apb_pstrb  = r_pstrb;
  assign rsp_rdata    = r_rdata;
  assign rsp_err      = r_err;
  assign rsp_timeout  = r_timeout;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Scoreboard bench for rtc_apb_master: directed commands push expected
// responses; a monitor pops and compares on each response handshake.
module tb_rtc_apb_master;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int TIMEOUT = 16;

  logic              pclk = 1'b0;
  logic              prst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [STRB_W-1:0] cmd_strb = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic [ADDR_W-1:0] m_apb_paddr;
  logic              m_apb_psel;
  logic              m_apb_penable;
  logic              m_apb_pwrite;
  logic [DATA_W-1:0] m_apb_pwdata;
  logic [STRB_W-1:0] m_apb_pstrb;
  logic              m_apb_pready = 1'b0;
  logic [DATA_W-1:0] m_apb_prdata = '0;
  logic              m_apb_pslverr = 1'b0;

  rtc_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prst_n(prst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m_apb_paddr(m_apb_paddr), .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
    .m_apb_pwrite(m_apb_pwrite), .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pready(m_apb_pready), .m_apb_prdata(m_apb_prdata), .m_apb_pslverr(m_apb_pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              to;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_rsp  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: the handshake completes at the next rising edge.
  always @(negedge pclk) begin
    rsp_t e;
    if (prst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
      end
      n_rsp++;
    end
  end

  // Slave model: pready after sl_wait wait states (sl_wait < 0 never answers),
  // plus a check that the request fields hold while psel is high.
  int                acc_cnt  = 0;
  int                acc_last = 0;
  int                sl_wait  = 0;
  logic [DATA_W-1:0] sl_rdata = '0;
  logic              sl_err   = 1'b0;
  logic              chk_stab = 1'b0;
  logic [ADDR_W-1:0] ex_addr  = '0;
  logic [DATA_W-1:0] ex_wdata = '0;
  logic [STRB_W-1:0] ex_strb  = '0;
  logic              ex_write = 1'b0;

  always @(negedge pclk) begin
    if (m_apb_psel && m_apb_penable) begin
      acc_cnt  = acc_cnt + 1;
      acc_last = acc_cnt;
    end else begin
      acc_cnt = 0;
    end
    m_apb_pready  = m_apb_psel && m_apb_penable && (sl_wait >= 0) && (acc_cnt == sl_wait + 1);
    m_apb_prdata  = sl_rdata;
    m_apb_pslverr = sl_err && m_apb_pready;
    if (chk_stab && m_apb_psel) begin
      chk("apb_paddr", 64'(m_apb_paddr), 64'(ex_addr));
      chk("apb_pwdata", 64'(m_apb_pwdata), 64'(ex_wdata));
      chk("apb_pstrb", 64'(m_apb_pstrb), 64'(ex_strb));
      chk("apb_pwrite", 64'(m_apb_pwrite), 64'(ex_write));
    end
  end

  task automatic drive_cmd(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    ex_addr = a; ex_wdata = d; ex_strb = w ? s : '0; ex_write = w;
  endtask

  // Returns just after the accepting rising edge.
  task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    int t;
    @(negedge pclk);
    drive_cmd(w, a, d, s);
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge pclk);
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_wait", 64'd0, 64'd1);
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (n_rsp < target && t < 100) begin
      @(negedge pclk);
      t++;
    end
    if (n_rsp < target) chk("rsp_wait", 64'(n_rsp), 64'(target));
  endtask

  function automatic rsp_t mk(input logic [DATA_W-1:0] d, input logic e, input logic to);
    rsp_t r;
    r.rdata = d; r.err = e; r.to = to;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge pclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_psel", 64'(m_apb_psel), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_paddr", 64'(m_apb_paddr), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    #1 prst_n = 1'b1;
    repeat (2) @(negedge pclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk_stab = 1'b1;

    // Zero-wait read with latency checks
    sl_wait = 0; sl_rdata = 32'h0000_1234; sl_err = 1'b0;
    exp_q.push_back(mk(32'h0000_1234, 1'b0, 1'b0));
    issue(1'b0, 32'h04, 32'h0, 4'hF);
    @(negedge pclk);
    chk("t1_psel", 64'(m_apb_psel), 64'd1);
    chk("t1_penable", 64'(m_apb_penable), 64'd0);
    chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge pclk);
    chk("t2_psel", 64'(m_apb_psel), 64'd1);
    chk("t2_penable", 64'(m_apb_penable), 64'd1);
    chk("t2_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge pclk);
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t3_psel", 64'(m_apb_psel), 64'd0);
    wait_rsp(1);

    // Write with 3 wait states
    sl_wait = 3; sl_rdata = 32'hAAAA_5555;
    exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
    issue(1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF);
    wait_rsp(2);
    chk("wr_access_cycles", 64'(acc_last), 64'd4);

    // Slave error on read
    sl_wait = 0; sl_err = 1'b1; sl_rdata = 32'hCAFE_0001;
    exp_q.push_back(mk(32'hCAFE_0001, 1'b1, 1'b0));
    issue(1'b0, 32'hFFC, 32'h1111_2222, 4'hF);
    wait_rsp(3);
    sl_err = 1'b0;

    // Timeout with pready never arriving
    sl_wait = -1; sl_rdata = 32'h7777_8888;
    exp_q.push_back(mk(32'h0, 1'b1, 1'b1));
    issue(1'b0, 32'h10, 32'h0, 4'h3);
    wait_rsp(4);
    chk("to_access_cycles", 64'(acc_last), 64'd16);
    chk("to_psel_after", 64'(m_apb_psel), 64'd0);

    // pready on the 16th ACCESS cycle wins over timeout
    sl_wait = 15;
    exp_q.push_back(mk(32'h7777_8888, 1'b0, 1'b0));
    issue(1'b0, 32'h14, 32'h0, 4'h0);
    wait_rsp(5);
    chk("last_access_cycles", 64'(acc_last), 64'd16);

    // Backpressure, then back-to-back acceptance with cmd_valid held high
    sl_wait = 0; sl_rdata = 32'h0000_5A5A;
    exp_q.push_back(mk(32'h0000_5A5A, 1'b0, 1'b0));
    @(negedge pclk);
    rsp_ready = 1'b0;
    drive_cmd(1'b0, 32'h20, 32'h0, 4'hF);
    chk("bp_cmd_ready_idle", 64'(cmd_ready), 64'd1);
    repeat (3) @(negedge pclk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("bp_rsp_rdata", 64'(rsp_rdata), 64'h5A5A);
      @(negedge pclk);
    end
    sl_rdata = 32'h0000_6B6B;
    exp_q.push_back(mk(32'h0000_6B6B, 1'b0, 1'b0));
    @(posedge pclk);
    #1 rsp_ready = 1'b1;
    @(negedge pclk);
    chk("hs_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge pclk);
    chk("b2b_cmd_ready", 64'(cmd_ready), 64'd1);
    @(posedge pclk);
    #1 cmd_valid = 1'b0;
    @(negedge pclk);
    chk("b2b_psel", 64'(m_apb_psel), 64'd1);
    chk("b2b_pstrb", 64'(m_apb_pstrb), 64'd0);
    wait_rsp(7);

    // Reset during ACCESS with pready low
    sl_wait = -1;
    issue(1'b0, 32'h30, 32'h0, 4'hF);
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_penable", 64'(m_apb_penable), 64'd1);
    #1 prst_n = 1'b0;
    #1;
    chk("mid_rst_psel", 64'(m_apb_psel), 64'd0);
    chk("mid_rst_penable", 64'(m_apb_penable), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge pclk);
    #1 prst_n = 1'b1;
    repeat (2) @(negedge pclk);
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
    sl_wait = 0; sl_rdata = 32'h0BAD_F00D;
    exp_q.push_back(mk(32'h0BAD_F00D, 1'b0, 1'b0));
    issue(1'b0, 32'h40, 32'h0, 4'hF);
    wait_rsp(8);

    repeat (2) @(negedge pclk);
    chk("rsp_count", 64'(n_rsp), 64'd8);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rtc_apb_master.md
Name: rtc_apb_master

Overview:
Single-outstanding APB3/APB4 requester that sits directly upstream of the RTC APB slave and drives its s_apb bus. It converts a valid/ready command stream from a testbench driver or CPU-side adapter into compliant SETUP/ACCESS transfers. It returns one response per command, including read data, slave error and a timeout indication when pready never arrives.

Parameters:
ADDR_W, 32, width of cmd_addr and m_apb_paddr
DATA_W, 32, width of data buses; strobe width is DATA_W/8
TIMEOUT, 16, maximum ACCESS cycles to wait for pready before aborting; 0 disables the timeout

Ports:
pclk  in  1  APB clock
prst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when high with rsp_valid
rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts
rsp_err  out  1  pslverr seen, or timeout
rsp_timeout  out  1  transfer aborted by timeout
m_apb_paddr  out  ADDR_W  APB address
m_apb_psel  out  1  APB select
m_apb_penable  out  1  APB enable
m_apb_pwrite  out  1  APB direction
m_apb_pwdata  out  DATA_W  APB write data
m_apb_pstrb  out  DATA_W/8  APB strobes; forced to 0 on reads
m_apb_pready  in  1  slave ready
m_apb_prdata  in  DATA_W  slave read data
m_apb_pslverr  in  1  slave error

Behaviour:
- Reset:
  - All outputs go to 0 asynchronously.
  - FSM goes to IDLE and the timeout counter clears.
  - Reset mid-transfer drops psel/penable immediately. The command is lost and no response is produced.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1; cmd_ready is 0 in every other state.
  - On cmd_valid, register addr, write, wdata and strb (strb zeroed if read), then go to SETUP.
- SETUP:
  - psel = 1, penable = 0.
  - Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel = 1, penable = 1; counter increments each ACCESS cycle, first ACCESS cycle has count = 1.
  - If pready = 1: capture prdata (reads only; writes return 0) and pslverr into rsp_err, rsp_timeout = 0, go to RESP.
  - Else if TIMEOUT != 0 and count == TIMEOUT: rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, go to RESP.
  - pready takes priority over timeout when both occur in the same cycle.
- RESP:
  - psel = 0, penable = 0, rsp_valid = 1.
  - Response fields are held stable until rsp_ready. On rsp_valid & rsp_ready go to IDLE and clear rsp_valid.
- APB output stability:
  - paddr, pwrite, pwdata and pstrb are stable from SETUP through the final ACCESS cycle.
  - They keep their last value in IDLE/RESP; no glitch to 0 is required.
  - psel and penable never toggle while pready is pending.
- Latency: command accepted at cycle T gives SETUP at T+1, first ACCESS at T+2, and rsp_valid at T+3 with zero-wait pready.
- Throughput: cmd_ready reasserts the cycle after the response handshake. Back-to-back commands are separated by at least 4 cycles.
- pslverr is sampled only in the ACCESS cycle where pready = 1. prdata is ignored on writes.
- Timeout counter width is clog2(TIMEOUT+1) and saturates. It clears on entry to SETUP.

Test Plan:
- Zero-wait read: cmd addr 0x04, slave returns pready=1 with prdata 0x0000_1234 in first ACCESS cycle -> psel rises at T+1, penable at T+2, rsp_valid at T+3 with rsp_rdata 0x1234, rsp_err 0, rsp_timeout 0.
- Write with 3 wait states: cmd_write, addr 0x08, wdata 0xDEAD_BEEF, strb 0xF; pready on 4th ACCESS cycle -> paddr/pwdata/pstrb stable across all 4 ACCESS cycles, rsp_rdata 0, rsp_err 0.
- Slave error: read addr 0xFFC, pready=1 with pslverr=1 -> rsp_err 1, rsp_timeout 0, rsp_rdata equals prdata.
- Timeout: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_valid with rsp_err 1, rsp_timeout 1. Repeat with pready=1 on cycle 16 -> normal completion.
- Backpressure and back-to-back: rsp_ready held 0 for 5 cycles with cmd_valid continuously high -> rsp fields stable, cmd_ready 0 throughout. Second command is accepted the cycle after the handshake; read strobes are observed as 0.
- Reset mid-ACCESS: prst_n asserted during ACCESS with pready 0 -> psel/penable/rsp_valid drop to 0 immediately. After release, cmd_ready = 1 and a fresh read completes normally.
